// File: rtl/cache_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_mem_pkg: line geometry and bridge state shared by the cache side.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cache_mem_pkg;

  localparam int LINE_WORDS = 8;
  localparam int LINE_BYTES = 32;
  localparam int OFFSET_W   = 5;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } bridge_state_e;

endpackage : cache_mem_pkg
`default_nettype wire

// File: rtl/cache_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_mem_bridge: serialises one 256-bit cache line request into eight   |
// | 32-bit memory beats and reassembles fill data into a full line.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cache_mem_bridge
  import cache_mem_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_req_en,
  input  logic                           i_req_write,
  input  logic [ADDR_W-1:0]              i_req_addr,
  input  logic [LINE_WORDS*WORD_W-1:0]   i_wline,
  output logic                           o_resp,
  output logic [LINE_WORDS*WORD_W-1:0]   o_rline,
  output logic                           o_mem_valid,
  output logic                           o_mem_we,
  output logic [ADDR_W-1:0]              o_mem_addr,
  output logic [WORD_W-1:0]              o_mem_wdata,
  input  logic                           i_mem_ready,
  input  logic                           i_mem_rvalid,
  input  logic [WORD_W-1:0]              i_mem_rdata
);

  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int LANE_W = OFFSET_W - CNT_W;
  localparam int LINE_W = LINE_WORDS * WORD_W;

  bridge_state_e              r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_write;
  logic [ADDR_W-OFFSET_W-1:0] r_base_hi;
  logic [LINE_W-1:0]          r_wline;
  logic [LINE_W-1:0]          r_rline;
  logic                       r_resp;
  logic                       r_mem_valid;
  logic                       r_mem_we;
  logic [ADDR_W-1:0]          r_mem_addr;
  logic [WORD_W-1:0]          r_mem_wdata;

  logic [CNT_W-1:0]           w_cnt_inc;
  logic                       w_last;
  logic [ADDR_W-1:0]          w_next_addr;
  logic                       w_unused;

  // The base is line aligned, so a beat address is just base | word index.
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_last      = (r_cnt == CNT_W'(LINE_WORDS - 1));
  assign w_next_addr = {r_base_hi, w_cnt_inc, {LANE_W{1'b0}}};
  assign w_unused    = ^i_req_addr[OFFSET_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_base_hi   <= '0;
      r_wline     <= '0;
      r_rline     <= '0;
      r_resp      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req_en) begin
            r_write     <= i_req_write;
            r_base_hi   <= i_req_addr[ADDR_W-1:OFFSET_W];
            r_wline     <= i_wline;
            r_cnt       <= '0;
            r_mem_valid <= 1'b1;
            r_mem_we    <= i_req_write;
            r_mem_addr  <= {i_req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            r_mem_wdata <= i_req_write ? i_wline[WORD_W-1:0] : '0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_mem_ready) begin
            if (r_write) begin
              if (w_last) begin
                r_mem_valid <= 1'b0;
                r_resp      <= 1'b1;
                r_state     <= RESP;
              end else begin
                r_cnt       <= w_cnt_inc;
                r_mem_addr  <= w_next_addr;
                r_mem_wdata <= r_wline[w_cnt_inc*WORD_W +: WORD_W];
              end
            end else begin
              r_mem_valid <= 1'b0;
              r_state     <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (i_mem_rvalid) begin
            r_rline[r_cnt*WORD_W +: WORD_W] <= i_mem_rdata;
            if (w_last) begin
              r_resp  <= 1'b1;
              r_state <= RESP;
            end else begin
              r_cnt       <= w_cnt_inc;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_next_addr;
              r_mem_wdata <= '0;
              r_state     <= ISSUE;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_resp      = r_resp;
  assign o_rline     = r_rline;
  assign o_mem_valid = r_mem_valid;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule : cache_mem_bridge
`default_nettype wire

// File: tb/tb_cache_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cache_mem_bridge: directed and randomized line transfers against a    |
// | beat-level memory model with configurable stalls.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cache_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_en;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [255:0] wline;
  logic         resp;
  logic [255:0] rline;
  logic         mem_valid;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  always #5 clk = ~clk;

  cache_mem_bridge #(.LINE_WORDS(8), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_en    (req_en),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_wline     (wline),
    .o_resp      (resp),
    .o_rline     (rline),
    .o_mem_valid (mem_valid),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_ready (mem_ready),
    .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata (mem_rdata)
  );

  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [255:0] m_rline;
  int           g_rs[8];
  int           g_rd[8];
  bit           g_seq;
  bit           g_at_resp;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_stalls(input int rs_max, input int rd_max);
    for (int i = 0; i < 8; i++) begin
      g_rs[i] = (rs_max == 0) ? 0 : $urandom_range(0, rs_max);
      g_rd[i] = (rd_max <= 1) ? 1 : $urandom_range(1, rd_max);
    end
  endtask

  task automatic idle(input int n);
    req_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      mem_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_valid", mem_valid, 0);
      chk("idle_resp", resp, 0);
      chk("idle_rline", rline, m_rline);
    end
    mem_rvalid = 1'b0;
    g_at_resp  = 1'b0;
  endtask

  // One line request; beat k waits g_rs[k] cycles for ready and, for reads,
  // returns data g_rd[k] cycles after acceptance.
  task automatic do_req(input bit wr, input logic [31:0] addr,
                        input logic [255:0] line, input int abort_k);
    logic [31:0]  base;
    logic [255:0] exp_line;
    int k, ph, sc, d, exp_lat;
    bit done;
    base    = {addr[31:5], 5'b0};
    exp_lat = 1;
    for (int i = 0; i < 8; i++) exp_lat += 1 + g_rs[i] + (wr ? 0 : g_rd[i]);
    exp_line  = m_rline;
    req_en    = 1'b1;
    req_write = wr;
    req_addr  = addr;
    wline     = line;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    if (g_at_resp) begin
      @(negedge clk);
      chk("post_resp_valid", mem_valid, 0);
      chk("post_resp_resp", resp, 0);
    end
    g_at_resp = 1'b0;
    k = 0; ph = 0; sc = 0; d = 0; done = 1'b0;
    for (int t = 1; t <= 400 && !done; t++) begin
      @(negedge clk);
      req_addr  = $urandom;
      req_write = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) wline[32*i +: 32] = $urandom;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (ph == 0) begin
        if (k == abort_k) begin
          rst = 1'b1; req_en = 1'b0; mem_rvalid = 1'b1; mem_ready = 1'b1;
          @(negedge clk);
          chk("abort_valid", mem_valid, 0);
          chk("abort_rline", rline, 0);
          chk("abort_resp", resp, 0);
          chk("abort_addr", mem_addr, 0);
          rst = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
          m_rline = '0;
          @(negedge clk);
          chk("abort_resp2", resp, 0);
          chk("abort_valid2", mem_valid, 0);
          return;
        end
        chk("beat_valid", mem_valid, 1);
        chk("beat_addr", mem_addr, base + 32'(4 * k));
        chk("beat_we", mem_we, wr);
        chk("beat_wdata", mem_wdata, wr ? line[32*k +: 32] : 32'h0);
        chk("beat_resp", resp, 0);
        mem_rvalid = 1'($urandom_range(0, 1));
        if (sc >= g_rs[k]) begin
          mem_ready = 1'b1;
          sc = 0;
          if (wr) begin
            k++;
            if (k == 8) ph = 2;
          end else begin
            ph = 1; d = 0;
          end
        end else begin
          mem_ready = 1'b0;
          sc++;
        end
      end else if (ph == 1) begin
        chk("wait_valid", mem_valid, 0);
        chk("wait_resp", resp, 0);
        mem_ready = 1'($urandom_range(0, 1));
        d++;
        if (d == g_rd[k]) begin
          mem_rvalid = 1'b1;
          if (g_seq) mem_rdata = 32'h1000 + 32'(k);
          exp_line[32*k +: 32] = mem_rdata;
          k++;
          ph = (k == 8) ? 2 : 0;
        end
      end else begin
        chk("resp_pulse", resp, 1);
        chk("resp_cycle", t, exp_lat);
        m_rline = exp_line;
        chk("resp_rline", rline, m_rline);
        mem_ready  = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        done = 1'b1;
        g_at_resp = 1'b1;
      end
    end
    chk("req_timeout", done, 1);
  endtask

  initial begin
    logic [255:0] ln;
    logic [255:0] fill_exp;
    rst = 1'b1; req_en = 1'b0; req_write = 1'b0; req_addr = '0; wline = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    g_seq = 1'b0; g_at_resp = 1'b0; m_rline = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp", resp, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rline", rline, 0);
    rst = 1'b0;
    idle(4);

    // Directed write-back, no stalls: 9-cycle latency
    for (int i = 0; i < 8; i++) ln[32*i +: 32] = 32'hA0 + 32'(i);
    set_stalls(0, 1);
    do_req(1'b1, 32'h0000_1234, ln, 8);
    idle(2);

    // Directed fill, 1-cycle read latency: 17-cycle latency
    g_seq = 1'b1;
    do_req(1'b0, 32'h8000_0040, '0, 8);
    for (int i = 0; i < 8; i++) fill_exp[32*i +: 32] = 32'h1000 + 32'(i);
    chk("fill_line_const", rline, fill_exp);
    g_seq = 1'b0;
    idle(2);

    // Back-pressure: ready low 3 cycles on beat 4 / rvalid 5 cycles late on beat 6
    set_stalls(0, 1);
    g_rs[4] = 3;
    do_req(1'b1, 32'h0000_2000, ln, 8);
    idle(1);
    set_stalls(0, 1);
    g_rd[6] = 5;
    do_req(1'b0, 32'h0000_3004, '0, 8);
    idle(1);

    // Back-to-back with req_en held: write-back then fill
    set_stalls(0, 1);
    for (int i = 0; i < 8; i++) ln[32*i +: 32] = $urandom;
    do_req(1'b1, 32'h4000_0100, ln, 8);
    do_req(1'b0, 32'h4000_0200, '0, 8);
    idle(2);

    // Reset after three words of a fill, then a clean fill
    set_stalls(0, 1);
    do_req(1'b0, 32'h0000_5000, '0, 3);
    idle(1);
    do_req(1'b0, 32'h0000_6000, '0, 8);
    idle(1);

    // Randomized traffic with random stalls and optional back-to-back chaining
    for (int n = 0; n < 30; n++) begin
      set_stalls(3, 4);
      for (int i = 0; i < 8; i++) ln[32*i +: 32] = $urandom;
      do_req(1'($urandom_range(0, 1)), $urandom, ln, 8);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_cache_mem_bridge
`default_nettype wire
